// File: rtl/baud_ctrl.sv
// Baud-rate tick generator: one tick per divisor period, optional half-length
// first period for start-bit centring, and divisor changes applied only on period boundaries.
module baud_ctrl #(
  parameter int unsigned DIV_RST = 2500,
  parameter int unsigned TCNT_W  = 16
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic              stop,
  input  logic              align,
  input  logic              cfg_req,
  input  logic [31:0]       cfg_div,
  output logic              cfg_busy,
  output logic              cfg_ack,
  output logic              tick,
  output logic              clk_out,
  output logic              running,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic [1:0]        state_dbg
);

  // Config handshake: cfg_req is a single-cycle request accepted only while
  // cfg_busy is low; cfg_busy stays high until the divisor takes effect, which
  // is signalled by a one-cycle cfg_ack. Requests seen while busy are dropped.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  localparam logic [TCNT_W-1:0] TCNT_ONE = 1;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         div_q, div_d;
  logic [31:0]         pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                tick_q, tick_d;
  logic                clk_out_q, clk_out_d;
  logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                running_q;
  logic [31:0]         half_div;
  logic                period_end;
  logic                load_ok;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

  assign half_div   = {1'b0, div_q[31:1]};
  assign period_end = (state_q == S_ALIGN) ? (cnt_q == half_div - 32'd1)
                                           : (cnt_q == div_q - 32'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
    tick_cnt_d = tick_cnt_q;
    load_ok    = 1'b0;

    if (cfg_req && !busy_q) begin
      pend_d = cfg_div;
      busy_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        load_ok = busy_q;
        if (start && !stop) begin
          tick_cnt_d = '0;
          state_d    = align ? S_ALIGN : S_RUN;
        end
      end
      S_ALIGN, S_RUN: begin
        if (stop) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          clk_out_d = 1'b0;
          load_ok   = busy_q;
        end else if (period_end) begin
          // A pending divisor lands exactly on the period boundary.
          tick_d     = 1'b1;
          cnt_d      = '0;
          clk_out_d  = ~clk_out_q;
          tick_cnt_d = tick_cnt_q + TCNT_ONE;
          state_d    = S_RUN;
          load_ok    = busy_q;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_ok) begin
      div_d  = clamp_div(pend_q);
      busy_d = 1'b0;
      ack_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= clamp_div(32'(DIV_RST));
      pend_q     <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_cnt_q <= '0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      tick_cnt_q <= tick_cnt_d;
      running_q  <= (state_d != S_IDLE);
    end
  end

  assign cfg_busy  = busy_q;
  assign cfg_ack   = ack_q;
  assign tick      = tick_q;
  assign clk_out   = clk_out_q;
  assign running   = running_q;
  assign tick_cnt  = tick_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 Parameter: DIV_RST, 2500, divisor loaded at reset (48 MHz / 19.2 kHz).
REQ-002 Parameter: TCNT_W, 16, width of tick_cnt.
REQ-003 Port: clk  in  1  48 MHz system clock; the sole clock, all logic on its rising edge.
REQ-004 Port: res_n  in  1  reset, synchronous, active-low.
REQ-005 Port: start  in  1  one-cycle pulse; begin tick generation.
REQ-006 Port: stop  in  1  one-cycle pulse; halt tick generation.
REQ-007 Port: align  in  1  sampled with start; 1 = first period is half-length (RX start-bit centring).
REQ-008 Port: cfg_req  in  1  one-cycle pulse; request divisor change.
REQ-009 Port: cfg_div  in  32  requested divisor, in clk cycles per tick; valid with cfg_req.
REQ-010 Port: cfg_busy  out  1  high while a divisor change is pending.
REQ-011 Port: cfg_ack  out  1  one-cycle pulse; new divisor is in effect.
REQ-012 Port: tick  out  1  one-cycle pulse, once per divisor period.
REQ-013 Port: clk_out  out  1  square wave; toggles on every tick.
REQ-014 Port: running  out  1  high in states ALIGN and RUN.
REQ-015 Port: tick_cnt  out  TCNT_W  ticks issued since the last start.

Function
REQ-016 The block SHALL implement the states IDLE, ALIGN and RUN, with running = (state != IDLE).
REQ-017 The block SHALL hold the active divisor in div_q (32 bit) and clamp any loaded value below 2 to 2.
REQ-018 The block SHALL use a 32-bit period counter cnt, cleared in IDLE and incremented once per cycle in ALIGN and RUN.
REQ-019 On start in IDLE, the block SHALL clear cnt and tick_cnt and go to ALIGN if align=1, else to RUN.
REQ-020 In RUN, when cnt = div_q-1, the block SHALL clear cnt on the next edge and assert tick for that next cycle, giving tick period = div_q cycles and the first tick exactly div_q cycles after start is sampled.
REQ-021 In ALIGN, when cnt = (div_q>>1)-1, the block SHALL issue a tick, clear cnt and enter RUN; the first tick comes div_q>>1 cycles after start.
REQ-022 On each tick, the block SHALL toggle clk_out and increment tick_cnt, with tick_cnt wrapping from all-ones to 0.
REQ-023 The block SHALL ignore start outside IDLE.
REQ-024 On stop in ALIGN or RUN, the block SHALL enter IDLE on the next edge, clear cnt and clk_out, and hold tick_cnt; no tick is issued in the cycle after stop.
REQ-025 When start and stop are high in the same cycle, the block SHALL give stop priority, so start has no effect.
REQ-026 On cfg_req with cfg_busy=0, the block SHALL capture cfg_div into pend_q and raise cfg_busy on the next edge.
REQ-027 The block SHALL ignore cfg_req while cfg_busy=1, leaving pend_q unchanged.
REQ-028 In IDLE, the block SHALL load pend_q into div_q on the edge after capture and pulse cfg_ack with cfg_busy low in the following cycle, so the ack comes 2 cycles after cfg_req.
REQ-029 In ALIGN or RUN, the block SHALL load pend_q into div_q only on the edge that clears cnt for a tick, pulse cfg_ack in the same cycle as that tick and clear cfg_busy; the period in progress is never shortened or stretched.
REQ-030 If stop occurs while cfg_busy=1, the block SHALL load pend_q on the IDLE entry edge and pulse cfg_ack in the first IDLE cycle.
REQ-031 If start and the pending load coincide in IDLE, the block SHALL start with the newly loaded divisor.
REQ-032 When cnt = div_q-1 (RUN) or (div_q>>1)-1 (ALIGN) coincides with stop, the block SHALL give stop priority and suppress that tick.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 With res_n=0 at a clk edge, the block SHALL set: state=IDLE, cnt=0, div_q=DIV_RST, pend_q=0, cfg_busy=0, cfg_ack=0, tick=0, clk_out=0, tick_cnt=0.
REQ-035 Reset SHALL override start, stop and cfg_req in the same cycle, and any pending configuration SHALL be discarded without an ack.

Verification
REQ-036 The bench SHALL cover: reset, then cfg_div=10 loaded in IDLE and start with align=0 -> cfg_ack 2 cycles after cfg_req; ticks 10, 20, 30 cycles after start; clk_out period 20 cycles.
REQ-037 The bench SHALL cover: div_q=10, start with align=1 -> first tick 5 cycles after start, then every 10 cycles.
REQ-038 The bench SHALL cover: in RUN with div_q=10, cfg_req with cfg_div=4 at cnt=3 -> current period completes at 10; cfg_ack coincides with that tick; subsequent ticks every 4 cycles; a second cfg_req while busy is ignored.
REQ-039 The bench SHALL cover: cfg_div=0 and cfg_div=1 -> tick every 2 cycles; align start gives first tick after 1 cycle.
REQ-040 The bench SHALL cover: stop on the cycle where cnt=div_q-1 -> no tick, IDLE, clk_out=0, tick_cnt held; start+stop in the same IDLE cycle -> stays IDLE.
REQ-041 The bench SHALL cover: res_n=0 mid-RUN with cfg_busy=1 -> all outputs at reset values next cycle, no cfg_ack, div_q=2500; tick_cnt wraps from 65535 to 0 with TCNT_W=16.
